// File: rtl/dot_accel.sv
// Q16.16 dot-product accelerator: an Avalon-MM control slave plus a read-only
// master that fetches one weight/activation pair per element and accumulates.
module dot_accel (
  input  logic        clk,
  input  logic        rst,
  output logic        slave_waitrequest,
  input  logic [3:0]  slave_address,
  input  logic        slave_read,
  input  logic        slave_write,
  input  logic [31:0] slave_writedata,
  output logic [31:0] slave_readdata,
  input  logic        master_waitrequest,
  output logic [31:0] master_address,
  output logic        master_read,
  input  logic [31:0] master_readdata,
  input  logic        master_readdatavalid,
  output logic        master_write,
  output logic [31:0] master_writedata
);

  typedef enum logic [2:0] {IDLE, REQ_W, WAIT_W, REQ_A, WAIT_A, MAC} state_t;

  localparam logic [3:0] ADDR_CTRL  = 4'd0;
  localparam logic [3:0] ADDR_WBASE = 4'd2;
  localparam logic [3:0] ADDR_ABASE = 4'd3;
  localparam logic [3:0] ADDR_LEN   = 4'd5;

  state_t             r_state;
  logic [31:0]        r_acc;
  logic [31:0]        r_i;
  logic [31:0]        r_wbase;
  logic [31:0]        r_abase;
  logic [31:0]        r_len;
  logic signed [31:0] r_w;
  logic signed [31:0] r_a;
  logic               r_slave_wait;
  logic               r_master_read;
  logic [31:0]        r_master_addr;

  logic signed [63:0] w_product;
  logic [31:0]        w_i_next;
  logic               w_unused;

  assign w_product = 64'(r_w) * 64'(r_a);
  assign w_i_next  = r_i + 32'd1;

  // Reads decode purely on address; only the product's Q16.16 window is kept.
  assign w_unused = &{1'b0, slave_read, w_product[63:48], w_product[15:0]};

  assign slave_waitrequest = r_slave_wait;
  assign master_read       = r_master_read;
  assign master_address    = r_master_addr;
  assign master_write      = 1'b0;
  assign master_writedata  = 32'd0;

  always_comb begin
    // NOTE: default first so every path assigns the output and no latch is inferred.
    slave_readdata = 32'd0;
    case (slave_address)
      ADDR_CTRL:  slave_readdata = r_acc;
      ADDR_WBASE: slave_readdata = r_wbase;
      ADDR_ABASE: slave_readdata = r_abase;
      ADDR_LEN:   slave_readdata = r_len;
      default:    slave_readdata = 32'd0;
    endcase
  end

  // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_acc         <= '0;
      r_i           <= '0;
      r_wbase       <= '0;
      r_abase       <= '0;
      r_len         <= '0;
      r_w           <= '0;
      r_a           <= '0;
      r_slave_wait  <= 1'b0;
      r_master_read <= 1'b0;
      r_master_addr <= '0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (slave_write) begin
            case (slave_address)
              ADDR_CTRL: begin
                r_acc <= '0;
                r_i   <= '0;
                // An empty vector completes immediately with a zero result.
                if (r_len != 32'd0) begin
                  r_state       <= REQ_W;
                  r_slave_wait  <= 1'b1;
                  r_master_read <= 1'b1;
                  r_master_addr <= r_wbase;
                end
              end
              ADDR_WBASE: r_wbase <= slave_writedata;
              ADDR_ABASE: r_abase <= slave_writedata;
              ADDR_LEN:   r_len   <= slave_writedata;
              default: ;
            endcase
          end
        end

        REQ_W: begin
          if (!master_waitrequest) begin
            r_state       <= WAIT_W;
            r_master_read <= 1'b0;
          end
        end

        WAIT_W: begin
          if (master_readdatavalid) begin
            r_w           <= master_readdata;
            r_state       <= REQ_A;
            r_master_read <= 1'b1;
            r_master_addr <= r_abase + (r_i << 2);
          end
        end

        REQ_A: begin
          if (!master_waitrequest) begin
            r_state       <= WAIT_A;
            r_master_read <= 1'b0;
          end
        end

        WAIT_A: begin
          if (master_readdatavalid) begin
            r_a     <= master_readdata;
            r_state <= MAC;
          end
        end

        MAC: begin
          r_acc <= r_acc + w_product[47:16];
          r_i   <= w_i_next;
          if (w_i_next == r_len) begin
            r_state      <= IDLE;
            r_slave_wait <= 1'b0;
          end else begin
            r_state       <= REQ_W;
            r_master_read <= 1'b1;
            r_master_addr <= r_wbase + (w_i_next << 2);
          end
        end

        default: begin
          r_state       <= IDLE;
          r_slave_wait  <= 1'b0;
          r_master_read <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dot_accel.sv
// Directed bench for dot_accel: a memory responder with configurable stall and
// read latency, an address/result scoreboard, and immediate-assertion checks.
module tb_dot_accel;

  localparam int TIMEOUT = 2000;

  logic        clk = 1'b0;
  logic        rst;
  logic        slave_waitrequest;
  logic [3:0]  slave_address;
  logic        slave_read;
  logic        slave_write;
  logic [31:0] slave_writedata;
  logic [31:0] slave_readdata;
  logic        master_waitrequest;
  logic [31:0] master_address;
  logic        master_read;
  logic [31:0] master_readdata;
  logic        master_readdatavalid;
  logic        master_write;
  logic [31:0] master_writedata;

  always #5 clk = ~clk;

  dot_accel dut (
    .clk                  (clk),
    .rst                  (rst),
    .slave_waitrequest    (slave_waitrequest),
    .slave_address        (slave_address),
    .slave_read           (slave_read),
    .slave_write          (slave_write),
    .slave_writedata      (slave_writedata),
    .slave_readdata       (slave_readdata),
    .master_waitrequest   (master_waitrequest),
    .master_address       (master_address),
    .master_read          (master_read),
    .master_readdata      (master_readdata),
    .master_readdatavalid (master_readdatavalid),
    .master_write         (master_write),
    .master_writedata     (master_writedata)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] mem [int unsigned];
  logic [31:0] exp_addr_q [$];
  logic [31:0] exp_res_q [$];
  logic [31:0] vw [8];
  logic [31:0] va [8];

  int          stall_cfg    = 0;
  int          rd_lat       = 1;
  int          stall_cnt    = 0;
  int          rdv_cd       = 0;
  int          mread_pulses = 0;
  int          rdv_count    = 0;
  logic        prev_mread   = 1'b0;
  logic [31:0] hold_addr    = '0;
  logic [31:0] pend_addr    = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Q16.16 reference: full signed product, middle 32 bits, modulo-2^32 add.
  function automatic logic [31:0] q_mac(input logic [31:0] acc, input logic [31:0] w,
                                        input logic [31:0] a);
    logic signed [63:0] p;
    p = 64'($signed(w)) * 64'($signed(a));
    return acc + p[47:16];
  endfunction

  // Memory responder: decides waitrequest for the coming edge, returns data rd_lat cycles later.
  always @(negedge clk) begin
    master_readdatavalid = 1'b0;
    master_readdata      = 32'hDEAD_BEEF;
    if (rdv_cd > 0) begin
      rdv_cd--;
      if (rdv_cd == 0) begin
        master_readdatavalid = 1'b1;
        master_readdata      = mem.exists(pend_addr) ? mem[pend_addr] : 32'hDEAD_BEEF;
        rdv_count++;
      end
    end
    if (master_read && !prev_mread) mread_pulses++;
    prev_mread = master_read;
    if (stall_cnt > 0) begin
      check("mread_held_during_stall", 32'(master_read), 32'd1);
      check("maddr_held_during_stall", master_address, hold_addr);
    end
    if (!master_read) begin
      master_waitrequest = 1'b0;
      stall_cnt          = 0;
    end else if (stall_cnt < stall_cfg) begin
      if (stall_cnt == 0) hold_addr = master_address;
      master_waitrequest = 1'b1;
      stall_cnt++;
    end else begin
      master_waitrequest = 1'b0;
      stall_cnt          = 0;
      check("req_expected", 32'(exp_addr_q.size() > 0), 32'd1);
      if (exp_addr_q.size() > 0) check("req_addr_order", master_address, exp_addr_q.pop_front());
      pend_addr = master_address;
      rdv_cd    = rd_lat;
    end
  end

  task automatic slave_access(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                              output logic [31:0] rdata, output int waits);
    @(negedge clk);
    slave_address   = addr;
    slave_write     = wr;
    slave_read      = !wr;
    slave_writedata = wdata;
    waits = 0;
    #1;
    while (slave_waitrequest === 1'b1 && waits < TIMEOUT) begin
      @(negedge clk);
      #1;
      waits++;
    end
    if (waits >= TIMEOUT) check("slave_access_timeout", 32'(slave_waitrequest), 32'd0);
    rdata = slave_readdata;
    @(posedge clk);
    #1;
    slave_write = 1'b0;
    slave_read  = 1'b0;
  endtask

  task automatic wr_reg(input logic [3:0] addr, input logic [31:0] data);
    logic [31:0] unused_rd;
    int          unused_w;
    slave_access(1'b1, addr, data, unused_rd, unused_w);
  endtask

  task automatic rd_reg(input logic [3:0] addr, output logic [31:0] data, output int waits);
    slave_access(1'b0, addr, 32'd0, data, waits);
  endtask

  // One run: expected addresses and result go on the scoreboard before the start write.
  task automatic run_dot(input string tag, input logic [31:0] wb, input logic [31:0] ab,
                         input int n, input logic [31:0] exp_res, input bit early_read);
    logic [31:0] rd;
    int          waits;
    int          cyc;
    int          lat;
    int          p0;
    for (int k = 0; k < n; k++) begin
      mem[wb + 32'(4 * k)] = vw[k];
      mem[ab + 32'(4 * k)] = va[k];
      exp_addr_q.push_back(wb + 32'(4 * k));
      exp_addr_q.push_back(ab + 32'(4 * k));
    end
    exp_res_q.push_back(exp_res);
    wr_reg(4'd2, wb);
    wr_reg(4'd3, ab);
    wr_reg(4'd5, 32'(n));
    p0  = mread_pulses;
    lat = 5 * n + 1 + 2 * n * stall_cfg;
    wr_reg(4'd0, 32'hFFFF_FFFF);
    if (early_read) begin
      rd_reg(4'd0, rd, waits);
      check({tag, "_stalled_read_waits"}, 32'(waits), 32'(lat - 1));
    end else begin
      cyc = 0;
      do begin
        @(negedge clk);
        #1;
        cyc++;
      end while (slave_waitrequest === 1'b1 && cyc < TIMEOUT);
      check({tag, "_latency"}, 32'(cyc), 32'(lat));
      rd_reg(4'd0, rd, waits);
    end
    check({tag, "_result"}, rd, exp_res_q.pop_front());
    check({tag, "_req_count"}, 32'(mread_pulses - p0), 32'(2 * n));
    check({tag, "_addr_q_drained"}, 32'(exp_addr_q.size()), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] acc_m;
    int          waits;
    int          cyc;
    int          p0;
    int          rdv_before;

    rst                  = 1'b1;
    slave_address        = '0;
    slave_read           = 1'b0;
    slave_write          = 1'b0;
    slave_writedata      = '0;
    master_waitrequest   = 1'b0;
    master_readdata      = '0;
    master_readdatavalid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Reset state
    check("reset_waitrequest", 32'(slave_waitrequest), 32'd0);
    check("reset_master_read", 32'(master_read), 32'd0);
    check("reset_master_addr", master_address, 32'd0);
    check("reset_master_write", 32'(master_write), 32'd0);
    check("reset_master_wdata", master_writedata, 32'd0);
    rd_reg(4'd0, rd, waits);
    check("reset_result", rd, 32'd0);

    // Register map readback and unmapped offsets
    wr_reg(4'd2, 32'hA5A5_0004);
    wr_reg(4'd3, 32'h5A5A_0008);
    wr_reg(4'd5, 32'd7);
    wr_reg(4'd7, 32'h1234_5678);
    rd_reg(4'd2, rd, waits);
    check("reg_wbase", rd, 32'hA5A5_0004);
    rd_reg(4'd3, rd, waits);
    check("reg_abase", rd, 32'h5A5A_0008);
    rd_reg(4'd5, rd, waits);
    check("reg_len", rd, 32'd7);
    rd_reg(4'd7, rd, waits);
    check("reg_unmapped_7", rd, 32'd0);
    rd_reg(4'd1, rd, waits);
    check("reg_unmapped_1", rd, 32'd0);

    // 2.0 * 1.5
    vw[0] = 32'h0002_0000;  va[0] = 32'h0001_8000;
    run_dot("n1", 32'h1000, 32'h2000, 1, 32'h0003_0000, 1'b0);

    // {1.0, -2.0, 0.5} . {4.0, 1.0, 2.0}
    vw[0] = 32'h0001_0000;  va[0] = 32'h0004_0000;
    vw[1] = 32'hFFFE_0000;  va[1] = 32'h0001_0000;
    vw[2] = 32'h0000_8000;  va[2] = 32'h0002_0000;
    run_dot("n3", 32'h1000, 32'h2000, 3, 32'h0003_0000, 1'b0);

    // Empty vector clears the previous result and issues no reads
    run_dot("n0", 32'h1000, 32'h2000, 0, 32'h0000_0000, 1'b0);

    // Same vectors with three stall cycles per request
    stall_cfg = 3;
    vw[0] = 32'h0001_0000;  va[0] = 32'h0004_0000;
    vw[1] = 32'hFFFE_0000;  va[1] = 32'h0001_0000;
    vw[2] = 32'h0000_8000;  va[2] = 32'h0002_0000;
    run_dot("stall3", 32'h1000, 32'h2000, 3, 32'h0003_0000, 1'b0);
    stall_cfg = 0;

    // Read issued right after start stalls until the run ends: 3*2 + 1*(-2) = 4.0
    vw[0] = 32'h0003_0000;  va[0] = 32'h0002_0000;
    vw[1] = 32'h0001_0000;  va[1] = 32'hFFFE_0000;
    run_dot("early_read", 32'h1000, 32'h2000, 2, 32'h0004_0000, 1'b1);

    // Product window and accumulator both wrap modulo 2^32
    vw[0] = 32'h7FFF_0000;  va[0] = 32'h0002_0000;
    vw[1] = 32'h7FFF_0000;  va[1] = 32'h0002_0000;
    run_dot("wrap", 32'h1000, 32'h2000, 2, 32'hFFFC_0000, 1'b0);

    // Random values, weight addresses wrapping past 2^32, one stall per request
    stall_cfg = 1;
    acc_m = '0;
    for (int k = 0; k < 4; k++) begin
      vw[k] = 32'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
      va[k] = 32'($urandom_range(0, 32'h00FF_FFFF)) - 32'h0080_0000;
      acc_m = q_mac(acc_m, vw[k], va[k]);
    end
    run_dot("rand_wrapaddr", 32'hFFFF_FFF8, 32'h0000_0100, 4, acc_m, 1'b0);
    stall_cfg = 0;

    // Reset while waiting for the activation word; the data arrives after reset
    rd_lat = 4;
    mem[32'h3000] = 32'h0001_0000;  mem[32'h4000] = 32'h0002_0000;
    exp_addr_q.push_back(32'h3000);
    exp_addr_q.push_back(32'h4000);
    wr_reg(4'd2, 32'h3000);
    wr_reg(4'd3, 32'h4000);
    wr_reg(4'd5, 32'd2);
    wr_reg(4'd0, 32'd0);
    cyc = 0;
    do begin
      @(negedge clk);
      #1;
      cyc++;
    end while (!(master_read === 1'b1 && master_address === 32'h4000) && cyc < TIMEOUT);
    check("rst_reached_req_a", master_address, 32'h4000);
    rdv_before = rdv_count;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    p0  = mread_pulses;
    check("rst_waitrequest", 32'(slave_waitrequest), 32'd0);
    check("rst_master_read", 32'(master_read), 32'd0);
    check("rst_master_addr", master_address, 32'd0);
    rd_reg(4'd0, rd, waits);
    check("rst_result_cleared", rd, 32'd0);
    cyc = 0;
    while (rdv_count == rdv_before && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check("rst_late_rdv_delivered", 32'(rdv_count - rdv_before), 32'd1);
    repeat (2) @(negedge clk);
    #1;
    check("rst_late_rdv_idle", 32'(slave_waitrequest), 32'd0);
    check("rst_late_rdv_no_req", 32'(mread_pulses - p0), 32'd0);
    rd_reg(4'd0, rd, waits);
    check("rst_late_rdv_result", rd, 32'd0);
    rd_reg(4'd2, rd, waits);
    check("rst_wbase_cleared", rd, 32'd0);
    rd_reg(4'd3, rd, waits);
    check("rst_abase_cleared", rd, 32'd0);
    rd_reg(4'd5, rd, waits);
    check("rst_len_cleared", rd, 32'd0);
    check("rst_addr_q_drained", 32'(exp_addr_q.size()), 32'd0);
    rd_lat = 1;

    // Fresh run after reprogramming: 0.5*0.5 + 0.5*(-1.5) = -0.5
    vw[0] = 32'h0000_8000;  va[0] = 32'h0000_8000;
    vw[1] = 32'h0000_8000;  va[1] = 32'hFFFE_8000;
    run_dot("after_rst", 32'h3000, 32'h4000, 2, 32'hFFFF_8000, 1'b0);

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
